// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 8-digit packed BCD converter (shift-add-3).
// Saturates to SAT_PATTERN when the input exceeds 99_999_999.
module bin2bcd_seq #(
    parameter logic [31:0] SAT_PATTERN = 32'h99999999
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd,
    output logic        overflow
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] shreg;
    logic [31:0] shreg_next;
    logic [39:0] scratch;
    logic [39:0] scratch_next;
    logic [39:0] adjusted;
    logic [5:0]  count;
    logic        ovf_pend;
    logic        last;

    assign last = (count == 6'd31);

    // Ten scratch digits are needed so that values up to 2^32-1 convert without digit overflow.
    always_comb begin
        adjusted = scratch;
        for (int unsigned i = 0; i < 10; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        {scratch_next, shreg_next} = {adjusted, shreg} << 1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CONV;
            CONV: if (last)  state_next = IDLE;
            default:         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg    <= '0;
            scratch  <= '0;
            count    <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= bin;
                        scratch  <= '0;
                        count    <= '0;
                        ovf_pend <= (bin > 32'd99_999_999);
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    scratch <= scratch_next;
                    shreg   <= shreg_next;
                    count   <= count + 6'd1;
                    // The final step's shifted result is published on the same edge.
                    if (last) begin
                        bcd      <= ovf_pend ? SAT_PATTERN : scratch_next[31:0];
                        overflow <= ovf_pend;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus randomized conversions
// compared every cycle against an arithmetic reference model.
module tb_bin2bcd_seq;

    localparam logic [31:0] SAT = 32'h99999999;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bin = '0;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.SAT_PATTERN(SAT)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        logic [31:0]     r;
        longint unsigned x;
        if (v > 32'd99_999_999) return SAT;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request accepted while idle yields its result 32 edges later.
    logic        m_busy, m_done, m_ovf;
    logic [31:0] m_bcd, m_pend;
    int          m_left;

    always @(posedge clk) begin
        if (!resetn) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_bcd  <= '0;
            m_ovf  <= 1'b0;
            m_left <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_bcd  <= ref_bcd(m_pend);
                m_ovf  <= (m_pend > 32'd99_999_999);
            end else begin
                m_done <= 1'b0;
            end
            m_left <= m_left - 1;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_left <= 32;
                m_pend <= bin;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("bcd", bcd, m_bcd);
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    // Entered at a negedge with start already driven for the next edge.
    task automatic wait_result(input logic [31:0] exp_bcd, input logic exp_ovf, input string name);
        int n = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                bin = $urandom;
            end
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        check({name, " done_seen"}, {31'd0, seen}, 32'd1);
        check({name, " latency"}, n - 1, 32'd32);
        check({name, " busy_cycles"}, bcnt, 32'd32);
        check({name, " bcd"}, bcd, exp_bcd);
        check({name, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    task automatic convert(input logic [31:0] v, input logic [31:0] exp_bcd, input logic exp_ovf, input string name);
        start = 1'b1;
        bin = v;
        wait_result(exp_bcd, exp_ovf, name);
    endtask

    initial begin
        int dones;
        int t, last_t, ndone;
        logic [31:0] v;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset bcd", bcd, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        resetn = 1'b1;
        check_en = 1'b1;

        convert(32'd0, 32'h00000000, 1'b0, "zero");
        convert(32'd12_345_678, 32'h12345678, 1'b0, "12345678");
        convert(32'd99_999_999, 32'h99999999, 1'b0, "max_valid");
        convert(32'd100_000_000, 32'h99999999, 1'b1, "first_ovf");
        convert(32'hFFFFFFFF, 32'h99999999, 1'b1, "all_ones");

        // Starts while busy (E0+5 and E32) are ignored; start at E33 is accepted.
        dones = 0;
        start = 1'b1;
        bin = 32'd87_654_321;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (k == 33) begin
                check("ignore bcd", bcd, 32'h87654321);
                check("ignore overflow", {31'd0, overflow}, 32'd0);
            end
            start = (k == 5 || k == 32 || k == 33);
            bin = (k == 5) ? 32'd11_111_111 : (k == 32) ? 32'd22_222_222 :
                  (k == 33) ? 32'd33 : $urandom;
        end
        check("ignore single_done", dones, 32'd1);
        wait_result(32'h00000033, 1'b0, "accept_at_e33");

        // Reset mid-conversion aborts without a done pulse.
        start = 1'b1;
        bin = 32'd5555;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            resetn = (k == 10) ? 1'b0 : 1'b1;
        end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no_done", dones, 32'd0);
        check("abort bcd", bcd, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        convert(32'd407, 32'h00000407, 1'b0, "after_abort");

        // Start held high: a result every 33 clocks.
        start = 1'b1;
        bin = 32'd1;
        t = 0;
        last_t = -1;
        ndone = 0;
        while (t < 150 && ndone < 3) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (last_t >= 0) check("held period", t - last_t, 32'd33);
                check("held bcd", bcd, 32'h00000001);
                last_t = t;
                ndone++;
            end
        end
        start = 1'b0;
        check("held done_count", ndone, 32'd3);

        // Randomized conversions with start/bin noise while busy.
        for (int it = 0; it < 40; it++) begin
            int n;
            bit seen;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom_range(0, 99_999_999);
                2:       v = 32'd99_999_998 + $urandom_range(0, 3);
                default: v = $urandom_range(0, 9999);
            endcase
            start = 1'b1;
            bin = v;
            n = 0;
            seen = 1'b0;
            while (n < 100 && !seen) begin
                @(negedge clk);
                n++;
                seen = done;
                if (!seen) begin
                    start = 1'($urandom_range(0, 1));
                    bin = $urandom;
                end
            end
            start = 1'b0;
            check("rand done_seen", {31'd0, seen}, 32'd1);
            check("rand bcd", bcd, ref_bcd(v));
            check("rand overflow", {31'd0, overflow}, {31'd0, (v > 32'd99_999_999)});
        end

        repeat (3) @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
